// File: rtl/sys_top_pkg.sv
// rtl/sys_top_pkg.sv - shared command codes, enums and framing constants for sys_top
package sys_top_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // XOR of the data bits and the parity bit must equal this value (odd parity)
  localparam logic PARITY_ODD = 1'b1;

  // idle-high clocks inserted between the two bytes of an ALU result
  localparam int GAP_CLKS = 8;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV,
    ALU_AND, ALU_OR, ALU_NAND, ALU_NOR,
    ALU_XOR, ALU_XNOR, ALU_CMP_EQ, ALU_CMP_GT,
    ALU_CMP_LT, ALU_SHR, ALU_SHL, ALU_ZERO
  } alu_fn_e;

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B,
    ALU_FN, NOOP_FN, TX_LO, TX_GAP, TX_HI
  } ctrl_state_e;

endpackage

// File: rtl/sys_top_if.sv
// rtl/sys_top_if.sv - serial link and error-flag bundle of sys_top
interface sys_top_if;
  logic RX_IN;
  logic TX_OUT;
  logic par_err;
  logic stp_err;

  modport master (output RX_IN, input TX_OUT, input par_err, input stp_err);
  modport slave  (input RX_IN, output TX_OUT, output par_err, output stp_err);
endinterface

// File: rtl/sys_top_uart_rx_frame.sv
// rtl/sys_top_uart_rx_frame.sv - UART receiver: synchronizer, mid-bit sampling, parity/stop check
module uart_rx_frame
  import sys_top_pkg::*;
#(
  parameter int Data_width = 8,
  parameter int Prescale   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  output logic [Data_width-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_bad,
  output logic                  par_err,
  output logic                  stp_err
);
  localparam int CW = $clog2(Prescale + 1);
  localparam int BW = $clog2(Data_width + 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_e;

  rx_state_e state_q, state_d;
  logic sync1, sync2;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [Data_width-1:0] shreg;
  logic par_bit;
  logic mid, last, bad_par, bad_stp;

  assign mid     = (cnt == CW'(Prescale / 2));
  assign last    = (cnt == CW'(Prescale - 1));
  assign bad_par = ((^{shreg, par_bit}) != PARITY_ODD);
  assign bad_stp = !sync2;

  // two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
    end
  end

  // receiver state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  // receiver next state; a start bit that is high again at mid-bit is a glitch
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (!sync2) state_d = RX_START;
      RX_START: if (mid && sync2) state_d = RX_IDLE;
                else if (last) state_d = RX_DATA;
      RX_DATA:  if (last && bit_idx == BW'(Data_width)) state_d = RX_PAR;
      RX_PAR:   if (last) state_d = RX_STOP;
      RX_STOP:  if (mid) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // bit timing, deserializer and end-of-frame verdict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_bad   <= 1'b0;
      par_err  <= 1'b0;
      stp_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_bad   <= 1'b0;
      if (state_q == RX_IDLE) begin
        cnt     <= '0;
        bit_idx <= '0;
      end else begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (mid) begin
          case (state_q)
            RX_DATA: begin
              shreg   <= {sync2, shreg[Data_width-1:1]};
              bit_idx <= bit_idx + 1'b1;
            end
            RX_PAR: par_bit <= sync2;
            RX_STOP: begin
              par_err <= bad_par;
              stp_err <= bad_stp;
              if (bad_par || bad_stp) begin
                rx_bad <= 1'b1;
              end else begin
                rx_valid <= 1'b1;
                rx_data  <= shreg;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: rtl/sys_top.sv
// rtl/sys_top.sv - UART-commanded register file and ALU with serial responses
module sys_top
  import sys_top_pkg::*;
#(
  parameter int Data_width = 8,
  parameter int DEPTH      = 16,
  parameter int Prescale   = 8
) (
  input  logic     UART_CLK,
  input  logic     RST,
  sys_top_if.slave uart
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(Prescale + 1);
  localparam int FW  = Data_width + 3;
  localparam int BW  = $clog2(FW + 1);
  localparam int DW2 = 2 * Data_width;

  logic [Data_width-1:0] rx_data;
  logic rx_valid, rx_bad, par_err_w, stp_err_w;

  uart_rx_frame #(.Data_width(Data_width), .Prescale(Prescale)) u_rx (
    .clk(UART_CLK), .rst(RST), .rx_in(uart.RX_IN), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_bad(rx_bad), .par_err(par_err_w), .stp_err(stp_err_w)
  );
  assign uart.par_err = par_err_w;
  assign uart.stp_err = stp_err_w;

  logic [Data_width-1:0] rf [DEPTH];
  ctrl_state_e state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [DW2-1:0] resp_q, alu_res, a_ext, b_ext;
  logic resp_two_q;
  logic [3:0] gap_cnt;
  logic rf_we;
  logic [AW-1:0] rf_waddr;
  logic [Data_width-1:0] rf_wdata, tx_byte;
  logic tx_start, tx_busy, tx_done;
  logic [FW-1:0] tx_shreg;
  logic [CW-1:0] tx_cnt;
  logic [BW-1:0] tx_bits;

  assign a_ext = {{Data_width{1'b0}}, rf[0]};
  assign b_ext = {{Data_width{1'b0}}, rf[1]};

  // ALU on reg0/reg1, function taken from the byte currently being accepted
  always_comb begin
    alu_res = '0;
    case (alu_fn_e'(rx_data[3:0]))
      ALU_ADD:    alu_res = a_ext + b_ext;
      ALU_SUB:    alu_res = a_ext - b_ext;
      ALU_MUL:    alu_res = a_ext * b_ext;
      ALU_DIV:    alu_res = (rf[1] == '0) ? '0 : a_ext / b_ext;
      ALU_AND:    alu_res = a_ext & b_ext;
      ALU_OR:     alu_res = a_ext | b_ext;
      ALU_NAND:   alu_res = {{Data_width{1'b0}}, ~(rf[0] & rf[1])};
      ALU_NOR:    alu_res = {{Data_width{1'b0}}, ~(rf[0] | rf[1])};
      ALU_XOR:    alu_res = a_ext ^ b_ext;
      ALU_XNOR:   alu_res = {{Data_width{1'b0}}, ~(rf[0] ^ rf[1])};
      ALU_CMP_EQ: alu_res = (rf[0] == rf[1]) ? DW2'(1) : '0;
      ALU_CMP_GT: alu_res = (rf[0] > rf[1]) ? DW2'(2) : '0;
      ALU_CMP_LT: alu_res = (rf[0] < rf[1]) ? DW2'(3) : '0;
      ALU_SHR:    alu_res = a_ext >> 1;
      ALU_SHL:    alu_res = a_ext << 1;
      default:    alu_res = '0;
    endcase
  end

  // controller state register
  always_ff @(posedge UART_CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // controller next state, register-file writes and transmit requests
  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    tx_byte  = '0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (state_q)
      IDLE: if (rx_valid) begin
        case (rx_data)
          CMD_RF_WR:   state_d = WR_ADDR;
          CMD_RF_RD:   state_d = RD_ADDR;
          CMD_ALU_OP:  state_d = OP_A;
          CMD_ALU_NOP: state_d = NOOP_FN;
          default:     state_d = IDLE;
        endcase
      end
      WR_ADDR: if (rx_valid) state_d = WR_DATA;
      WR_DATA: if (rx_valid) begin
        rf_we = 1'b1; rf_waddr = addr_q; rf_wdata = rx_data; state_d = IDLE;
      end
      RD_ADDR: if (rx_valid) begin
        tx_start = 1'b1; tx_byte = rf[rx_data[AW-1:0]]; state_d = TX_LO;
      end
      OP_A: if (rx_valid) begin
        rf_we = 1'b1; rf_waddr = AW'(0); rf_wdata = rx_data; state_d = OP_B;
      end
      OP_B: if (rx_valid) begin
        rf_we = 1'b1; rf_waddr = AW'(1); rf_wdata = rx_data; state_d = ALU_FN;
      end
      ALU_FN, NOOP_FN: if (rx_valid) begin
        tx_start = 1'b1; tx_byte = alu_res[Data_width-1:0]; state_d = TX_LO;
      end
      TX_LO:  if (tx_done) state_d = resp_two_q ? TX_GAP : IDLE;
      TX_GAP: if (gap_cnt == 4'(GAP_CLKS - 1)) begin
        tx_start = 1'b1; tx_byte = resp_q[DW2-1:Data_width]; state_d = TX_HI;
      end
      TX_HI:  if (tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a corrupted frame abandons any half-received command; responses run to completion
    if (rx_bad && !(state_q inside {TX_LO, TX_GAP, TX_HI})) state_d = IDLE;
  end

  // command operands captured across frames and the gap timer
  always_ff @(posedge UART_CLK or posedge RST) begin
    if (RST) begin
      addr_q     <= '0;
      resp_q     <= '0;
      resp_two_q <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      if (state_q == WR_ADDR && rx_valid) addr_q <= rx_data[AW-1:0];
      if (state_q == RD_ADDR && rx_valid) resp_two_q <= 1'b0;
      if ((state_q == ALU_FN || state_q == NOOP_FN) && rx_valid) begin
        resp_q     <= alu_res;
        resp_two_q <= 1'b1;
      end
      gap_cnt <= (state_q == TX_GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  // register file
  always_ff @(posedge UART_CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  assign tx_done = tx_busy && (tx_cnt == CW'(Prescale - 1)) && (tx_bits == BW'(FW - 1));

  // transmit serializer: start, data LSB first, odd parity, stop
  always_ff @(posedge UART_CLK or posedge RST) begin
    if (RST) begin
      tx_busy  <= 1'b0;
      tx_shreg <= '1;
      tx_cnt   <= '0;
      tx_bits  <= '0;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      tx_shreg <= {1'b1, PARITY_ODD ^ (^tx_byte), tx_byte, 1'b0};
      tx_cnt   <= '0;
      tx_bits  <= '0;
    end else if (tx_busy) begin
      if (tx_cnt == CW'(Prescale - 1)) begin
        tx_cnt   <= '0;
        tx_shreg <= {1'b1, tx_shreg[FW-1:1]};
        tx_bits  <= tx_bits + 1'b1;
        if (tx_done) tx_busy <= 1'b0;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  assign uart.TX_OUT = tx_busy ? tx_shreg[0] : 1'b1;
endmodule

// File: tb/tb_sys_top.sv
// tb/tb_sys_top.sv - scoreboard bench for sys_top driven through its serial link
module tb_sys_top;
  import sys_top_pkg::*;

  localparam int PS = 8;

  logic UART_CLK_tb = 1'b0;
  logic RST_tb;
  sys_top_if uif();

  sys_top #(.Data_width(8), .DEPTH(16), .Prescale(PS)) dut (
    .UART_CLK(UART_CLK_tb), .RST(RST_tb), .uart(uif)
  );

  always #5 UART_CLK_tb = ~UART_CLK_tb;

  typedef struct packed { logic [7:0] d; logic gap; } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [7:0] m_rf [16];

  function automatic logic odd_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  function automatic logic [15:0] model_alu(input logic [3:0] fn, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, r;
    ia = a; ib = b;
    case (fn)
      4'd0:  r = ia + ib;
      4'd1:  r = ia - ib;
      4'd2:  r = ia * ib;
      4'd3:  r = (ib == 0) ? 0 : ia / ib;
      4'd4:  r = ia & ib;
      4'd5:  r = ia | ib;
      4'd6:  r = 255 - (ia & ib);
      4'd7:  r = 255 - (ia | ib);
      4'd8:  r = ia ^ ib;
      4'd9:  r = 255 - (ia ^ ib);
      4'd10: r = (ia == ib) ? 1 : 0;
      4'd11: r = (ia > ib) ? 2 : 0;
      4'd12: r = (ia < ib) ? 3 : 0;
      4'd13: r = ia / 2;
      4'd14: r = ia * 2;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par = 1'b0, input logic bad_stp = 1'b0);
    logic [10:0] f;
    f = {~bad_stp, odd_par(d) ^ bad_par, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      uif.RX_IN = f[k];
      repeat (PS) @(negedge UART_CLK_tb);
    end
    uif.RX_IN = 1'b1;
    repeat (PS + $urandom_range(0, 6)) @(negedge UART_CLK_tb);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge UART_CLK_tb);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (12) @(negedge UART_CLK_tb);
  endtask

  task automatic cmd_write(input logic [7:0] a, input logic [7:0] d);
    send_frame(CMD_RF_WR);
    send_frame(a);
    send_frame(d);
    m_rf[a[3:0]] = d;
  endtask

  task automatic cmd_read(input logic [7:0] a);
    send_frame(CMD_RF_RD);
    exp_q.push_back('{d: m_rf[a[3:0]], gap: 1'b0});
    send_frame(a);
    wait_drain();
  endtask

  task automatic push_result(input logic [15:0] r);
    exp_q.push_back('{d: r[7:0], gap: 1'b0});
    exp_q.push_back('{d: r[15:8], gap: 1'b1});
  endtask

  task automatic cmd_alu_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] fn);
    send_frame(CMD_ALU_OP);
    send_frame(a);
    send_frame(b);
    m_rf[0] = a;
    m_rf[1] = b;
    push_result(model_alu(fn[3:0], a, b));
    send_frame(fn);
    wait_drain();
  endtask

  task automatic cmd_alu_nop(input logic [7:0] fn);
    send_frame(CMD_ALU_NOP);
    push_result(model_alu(fn[3:0], m_rf[0], m_rf[1]));
    send_frame(fn);
    wait_drain();
  endtask

  // monitor: decode every TX frame at mid-bit and compare against the queue head
  initial begin : monitor
    int highs;
    logic [10:0] fr;
    logic ab;
    exp_t e;
    highs = 0;
    forever begin
      @(negedge UART_CLK_tb);
      if (RST_tb || uif.TX_OUT) begin
        highs = RST_tb ? 0 : highs + 1;
      end else begin
        ab = 1'b0;
        fr = '0;
        for (int k = 0; k < 11; k++) begin
          for (int c = 0; c < ((k == 0) ? PS / 2 : PS); c++) begin
            @(negedge UART_CLK_tb);
            if (RST_tb) ab = 1'b1;
          end
          fr[k] = uif.TX_OUT;
        end
        if (!ab) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_tx_frame actual=%h required=none", fr[8:1]);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", 16'(fr[8:1]), 16'(e.d));
            check("tx_stop_par_start", 16'({fr[10], fr[9], fr[0]}), 16'({1'b1, odd_par(e.d), 1'b0}));
            // 3 remaining stop-bit samples plus at least 8 idle clocks
            if (e.gap) check("tx_gap_ge_8", 16'(highs >= 11), 16'd1);
          end
        end
        highs = 0;
      end
    end
  end

  initial begin
    logic [7:0] a, b;
    int n;
    RST_tb = 1'b1;
    uif.RX_IN = 1'b1;
    for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
    repeat (3) @(negedge UART_CLK_tb);
    check("reset_tx_out", 16'(uif.TX_OUT), 16'd1);
    check("reset_par_err", 16'(uif.par_err), 16'd0);
    check("reset_stp_err", 16'(uif.stp_err), 16'd0);
    RST_tb = 1'b0;
    repeat (5) @(negedge UART_CLK_tb);

    cmd_write(8'h01, 8'h5A);
    repeat (100) @(negedge UART_CLK_tb);
    cmd_read(8'h01);
    cmd_alu_op(8'h5A, 8'h57, 8'h01);
    cmd_alu_nop(8'h02);

    send_frame(CMD_RF_RD);
    send_frame(8'h01, 1'b1, 1'b0);
    check("bad_parity_par_err", 16'(uif.par_err), 16'd1);
    check("bad_parity_stp_err", 16'(uif.stp_err), 16'd0);
    send_frame(CMD_RF_RD, 1'b0, 1'b1);
    check("bad_stop_par_err", 16'(uif.par_err), 16'd0);
    check("bad_stop_stp_err", 16'(uif.stp_err), 16'd1);
    repeat (40) @(negedge UART_CLK_tb);
    cmd_read(8'hF1);

    for (int f = 0; f < 16; f++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      cmd_alu_op(a, b, {4'($urandom_range(0, 15)), 4'(f)});
    end
    cmd_alu_op(8'h37, 8'h00, 8'h03);
    cmd_alu_op(8'h44, 8'h44, 8'h0A);
    cmd_alu_op(8'hFF, 8'h01, 8'h0E);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 4))
        0: cmd_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        1: cmd_read(8'($urandom_range(0, 255)));
        2: begin
          a = 8'($urandom_range(0, 255));
          b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom_range(0, 255));
          cmd_alu_op(a, b, 8'($urandom_range(0, 255)));
        end
        3: cmd_alu_nop(8'($urandom_range(0, 255)));
        default: send_frame(8'h3C);
      endcase
    end

    cmd_write(8'h01, 8'hC3);
    send_frame(CMD_RF_RD);
    send_frame(8'h01);
    n = 0;
    while (uif.TX_OUT && n < 400) begin
      @(negedge UART_CLK_tb);
      n++;
    end
    check("abort_tx_started", 16'(uif.TX_OUT), 16'd0);
    repeat (20) @(negedge UART_CLK_tb);
    RST_tb = 1'b1;
    #1;
    check("abort_tx_out_high", 16'(uif.TX_OUT), 16'd1);
    for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
    repeat (3) @(negedge UART_CLK_tb);
    RST_tb = 1'b0;
    repeat (5) @(negedge UART_CLK_tb);
    check("abort_par_err", 16'(uif.par_err), 16'd0);
    check("abort_stp_err", 16'(uif.stp_err), 16'd0);
    cmd_read(8'h01);

    check("pending_responses", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sys_top.md
Name: sys_top

Overview:
- UART-controlled register-file/ALU subsystem on a single clock.
- Receives 8-bit command frames on RX_IN, decodes four commands (RF write, RF read, ALU with operands, ALU without operands) and executes them on an internal register file and a 16-bit-result ALU.
- Returns results as UART frames on TX_OUT.
- Sits at the top of the design; fixed-configuration serial link, no software-programmable UART settings.

Parameters:
- Data_width, 8, data/operand width and UART payload width.
- DEPTH, 16, register-file entries (address = low log2(DEPTH) bits of address byte).
- Prescale, 8, clocks per UART bit, for both RX and TX.

Ports:
- UART_CLK  in  1  sole clock for all logic.
- RST  in  1  asynchronous, active-high reset.
- RX_IN  in  1  serial input; idle high.
- TX_OUT  out  1  serial output; idle high.
- par_err  out  1  parity error of last received frame.
- stp_err  out  1  stop-bit error of last received frame.

Behaviour:
- Reset values: TX_OUT=1, par_err=0, stp_err=0, all register-file entries 0, FSM in IDLE.
- Reset mid-frame or mid-command aborts everything immediately.
- Frame format (RX and TX): start 0, 8 data bits LSB first, ODD parity bit (data ones + parity = odd), stop 1. Each bit lasts Prescale clocks.
- RX: RX_IN passes through a 2-flop synchronizer. A low level in idle starts a frame. The start bit is re-checked at mid-bit (count Prescale/2); if it is high, the event is a glitch and RX returns to idle. Every later bit is sampled at mid-bit.
- RX error flags: at stop-bit sample time, par_err and stp_err are updated. They hold until the next frame completes.
- A frame with any error is discarded and the controller returns to IDLE.
- Controller states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FN, NOOP_FN, TX_LO, TX_GAP, TX_HI.
- 0xAA (RF write): next byte = address, next byte = data; the data is written. No response.
- 0xBB (RF read): next byte = address; the register content is sent as one frame.
- 0xCC (ALU with operands): next bytes are A, B, function. A is written to reg0 and B to reg1; the ALU computes on reg0/reg1.
- 0xDD (ALU without operands): next byte = function; the ALU uses the current reg0/reg1.
- ALU response: 16-bit result sent low byte first, then a minimum 8-clock idle-high gap, then the high byte.
- Any other first byte is ignored; the controller stays in IDLE.
- Frames arriving while a response is being transmitted are dropped.
- Response start latency: the TX start bit begins within 4 clocks of the final command frame's stop-bit sample.
- ALU function (low 4 bits of function byte), 16-bit result, zero-extended unless noted:
  - 0: A+B
  - 1: A−B (two's complement in 16 bits)
  - 2: A*B
  - 3: A/B (0 if B=0)
  - 4: AND
  - 5: OR
  - 6: NAND
  - 7: NOR
  - 8: XOR
  - 9: XNOR
  - 10: 1 if A==B else 0
  - 11: 2 if A>B else 0
  - 12: 3 if A<B else 0
  - 13: A>>1
  - 14: A<<1
  - 15: 0
- Address byte upper bits beyond log2(DEPTH) are ignored.

Decomposition:
- Shared package:
  - command codes CMD_RF_WR=0xAA, CMD_RF_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD
  - ALU function enum (16 codes)
  - controller state enum
  - the odd-parity constant
- One natural sub-module: uart_rx_frame (synchronizer, oversampling counter, deserializer, parity/stop check; outputs byte, valid pulse, par_err, stp_err).
- TX serializer, controller, register file and ALU stay in sys_top.

Test Plan:
- Reset, then send frames 0xAA, 0x01, 0x5A -> no TX activity; TX_OUT stays 1.
- Send 0xBB, 0x01 -> one TX frame with data 0x5A, parity 1, stop 1 (bit sequence 0,0,1,0,1,1,0,1,0,1,1).
- Send 0xCC, 0x5A, 0x57, 0x01 -> frames 0x03 (parity 1) then 0x00 (parity 1), with ≥8-clock idle gap between them.
- Send 0xDD, 0x02 -> frames 0x96 (parity 1) then 0x1E (parity 1), i.e. 0x5A*0x57=0x1E96.
- Send 0xBB frame with wrong parity bit -> par_err=1, no response. Send 0xBB frame with stop bit 0 -> stp_err=1, no response.
- Assert RST during TX of a read response -> TX_OUT=1 immediately. Then 0xBB, 0x01 -> response data 0x00.
